// File: rtl/task_responder.sv
// Call/response responder: copies in a 4-bit argument, runs two timed steps, returns (a*MUL_K) mod 16.
// Optional trace ports dbg_valid/dbg_val are added when TASK_RESPONDER_TRACE_EN is defined.
module task_responder #(
  parameter int unsigned STEP_CYCLES = 2,
  parameter logic [3:0]  ADD_K       = 4'd3,
  parameter logic [3:0]  MUL_K       = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_out
`ifdef TASK_RESPONDER_TRACE_EN
  ,
  output logic       dbg_valid,
  output logic [3:0] dbg_val
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(STEP_CYCLES - 1);

  function automatic logic [3:0] add_mod16(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[3:0];
  endfunction

  function automatic logic [3:0] mul_mod16(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] prod;
    prod = {4'd0, a} * {4'd0, b};
    return prod[3:0];
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_loc_q, a_loc_d;
  logic [3:0] tmp_q, tmp_d;
  logic [3:0] rsp_out_q, rsp_out_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       step_done_s;
  logic       step1_fire_s;
  logic       step2_fire_s;

  assign step_done_s  = (cnt_q == LAST_CNT);
  assign step1_fire_s = (state_q == STEP1) && step_done_s;
  assign step2_fire_s = (state_q == STEP2) && step_done_s;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;

  // Next-state logic: the step counter times each step; rsp_out is written only on the final step.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_loc_d     = a_loc_q;
    tmp_d       = tmp_q;
    rsp_out_d   = rsp_out_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_loc_d = req_a;
          cnt_d   = 4'd0;
          state_d = STEP1;
        end else begin
          state_d = IDLE;
        end
      end
      STEP1: begin
        if (step_done_s) begin
          tmp_d   = add_mod16(a_loc_q, ADD_K);
          cnt_d   = 4'd0;
          state_d = STEP2;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STEP2: begin
        if (step_done_s) begin
          rsp_out_d   = mul_mod16(a_loc_q, MUL_K);
          rsp_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any call in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_loc_q     <= 4'd0;
      tmp_q       <= 4'd0;
      rsp_out_q   <= 4'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_loc_q     <= a_loc_d;
      tmp_q       <= tmp_d;
      rsp_out_q   <= rsp_out_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef TASK_RESPONDER_TRACE_EN
  logic       dbg_valid_q, dbg_valid_d;
  logic [3:0] dbg_val_q, dbg_val_d;

  // Trace pulse mirrors the values committed at the two step edges.
  always_comb begin
    dbg_valid_d = 1'b0;
    dbg_val_d   = dbg_val_q;
    if (step1_fire_s) begin
      dbg_valid_d = 1'b1;
      dbg_val_d   = tmp_d;
    end else if (step2_fire_s) begin
      dbg_valid_d = 1'b1;
      dbg_val_d   = rsp_out_d;
    end else begin
      dbg_valid_d = 1'b0;
    end
  end

  // Trace output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_valid_q <= 1'b0;
      dbg_val_q   <= 4'd0;
    end else begin
      dbg_valid_q <= dbg_valid_d;
      dbg_val_q   <= dbg_val_d;
    end
  end

  assign dbg_valid = dbg_valid_q;
  assign dbg_val   = dbg_val_q;
`endif

endmodule

// File: tb/tb_task_responder.sv
// Directed bench for task_responder with default parameters (STEP_CYCLES=2, ADD_K=3, MUL_K=5).
module tb_task_responder;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
`ifdef TASK_RESPONDER_TRACE_EN
  logic       dbg_valid;
  logic [3:0] dbg_val;
`endif

  int errors = 0;
  int checks = 0;

  task_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out)
`ifdef TASK_RESPONDER_TRACE_EN
    ,
    .dbg_valid (dbg_valid),
    .dbg_val   (dbg_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One complete call with rsp_ready high; prev is the rsp_out value expected before completion.
  task automatic do_call(input logic [3:0] a, input logic [3:0] exp_tmp,
                         input logic [3:0] exp_rsp, input logic [3:0] prev);
    req_valid = 1'b1;
    req_a     = a;
    rsp_ready = 1'b1;
    tick();
    check("accept_req_ready", {7'd0, req_ready}, 8'd0);
    req_valid = 1'b0;
    tick();
    check("e1_rsp_valid", {7'd0, rsp_valid}, 8'd0);
`ifdef TASK_RESPONDER_TRACE_EN
    check("e1_dbg_valid", {7'd0, dbg_valid}, 8'd0);
`endif
    tick();
`ifdef TASK_RESPONDER_TRACE_EN
    check("e2_dbg_valid", {7'd0, dbg_valid}, 8'd1);
    check("e2_dbg_val", {4'd0, dbg_val}, {4'd0, exp_tmp});
`else
    check("e2_rsp_out_prev", {4'd0, rsp_out}, {4'd0, prev});
`endif
    tick();
    check("e3_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("e3_rsp_out_prev", {4'd0, rsp_out}, {4'd0, prev});
`ifdef TASK_RESPONDER_TRACE_EN
    check("e3_dbg_valid", {7'd0, dbg_valid}, 8'd0);
`endif
    tick();
    check("e4_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("e4_rsp_out", {4'd0, rsp_out}, {4'd0, exp_rsp});
`ifdef TASK_RESPONDER_TRACE_EN
    check("e4_dbg_valid", {7'd0, dbg_valid}, 8'd1);
    check("e4_dbg_val", {4'd0, dbg_val}, {4'd0, exp_rsp});
`endif
    tick();
    check("hs_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("hs_req_ready", {7'd0, req_ready}, 8'd1);
    check("hs_rsp_out_kept", {4'd0, rsp_out}, {4'd0, exp_rsp});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = 4'd0;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", {7'd0, req_ready}, 8'd1);
    check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("rst_rsp_out", {4'd0, rsp_out}, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic calls, including wrap-around and zero.
    do_call(4'd2, 4'd5, 4'd10, 4'd0);
    do_call(4'd5, 4'd8, 4'd9, 4'd10);
    do_call(4'd0, 4'd3, 4'd0, 4'd9);

    // Copy-in: argument changes after acceptance, and req_valid mid-call is ignored.
    req_valid = 1'b1;
    req_a     = 4'd2;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a     = 4'd7;
    tick();
    req_valid = 1'b1;
    tick();
    check("ci_req_ready_busy", {7'd0, req_ready}, 8'd0);
    req_valid = 1'b0;
    tick();
    check("ci_rsp_out_prev", {4'd0, rsp_out}, 8'd0);
    tick();
    check("ci_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("ci_rsp_out", {4'd0, rsp_out}, 8'd10);
    tick();
    check("ci_hs_req_ready", {7'd0, req_ready}, 8'd1);

    // Backpressure with a pending request: no turnaround until after the handshake.
    req_valid = 1'b1;
    req_a     = 4'd5;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("bp_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    check("bp_rsp_out", {4'd0, rsp_out}, 8'd9);
    req_valid = 1'b1;
    req_a     = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", {7'd0, rsp_valid}, 8'd1);
      check("bp_hold_out", {4'd0, rsp_out}, 8'd9);
      check("bp_hold_req_ready", {7'd0, req_ready}, 8'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_hs_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("bp_hs_req_ready", {7'd0, req_ready}, 8'd1);
    tick();
    check("bp_new_accept", {7'd0, req_ready}, 8'd0);
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("bp_new_out_prev", {4'd0, rsp_out}, 8'd9);
    tick();
    check("bp_new_valid", {7'd0, rsp_valid}, 8'd1);
    check("bp_new_out", {4'd0, rsp_out}, 8'd0);
    tick();
    check("bp_new_hs", {7'd0, rsp_valid}, 8'd0);

    // Nonzero result, then a reset mid-call clears it and aborts the call.
    do_call(4'd15, 4'd2, 4'd11, 4'd0);
    req_valid = 1'b1;
    req_a     = 4'd3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("mrst_rsp_out", {4'd0, rsp_out}, 8'd0);
    check("mrst_req_ready", {7'd0, req_ready}, 8'd1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mrst_no_rsp", {7'd0, rsp_valid}, 8'd0);
    check("mrst_idle", {7'd0, req_ready}, 8'd1);
    do_call(4'd3, 4'd6, 4'd15, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/task_responder.md
TASK_RESPONDER -- requirements
Module: task_responder

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter STEP_CYCLES, default 2: clock cycles per computation step; legal range 1..15.
REQ-003 Parameter ADD_K, default 3: 4-bit constant used by the intermediate step.
REQ-004 Parameter MUL_K, default 5: 4-bit constant used by the final step.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port req_valid, input, 1: caller presents a call.
REQ-008 Port req_ready, output, 1: responder idle and able to accept a call.
REQ-009 Port req_a, input, 4: call argument, copied in at acceptance.
REQ-010 Port rsp_valid, output, 1: final result available.
REQ-011 Port rsp_ready, input, 1: caller consumes the result.
REQ-012 Port rsp_out, output, 4: result register; the only value ever copied out.

Function
REQ-013 SHALL implement FSM states IDLE, STEP1, STEP2 and DONE.
REQ-014 req_ready SHALL be 1 only in IDLE; acceptance occurs at the edge where req_valid=1 and req_ready=1 (edge E0).
REQ-015 At E0, req_a SHALL be copied into local register a_loc, the step counter SHALL clear, and the FSM SHALL enter STEP1.
REQ-016 req_a changes after E0 SHALL NOT affect the call in progress (copy-in semantics).
REQ-017 At edge E0+STEP_CYCLES, tmp SHALL take (a_loc+ADD_K) mod 16 and the FSM SHALL enter STEP2; tmp is internal only and never drives rsp_out.
REQ-018 At edge E0+2*STEP_CYCLES, rsp_out SHALL take (a_loc*MUL_K) mod 16, rsp_valid SHALL rise, and the FSM SHALL enter DONE.
REQ-019 rsp_out SHALL change only at the REQ-018 edge or on reset, so the caller sees only the last assigned value.
REQ-020 In DONE, rsp_valid and rsp_out SHALL hold stable until rsp_ready=1; at that edge rsp_valid SHALL fall and the FSM SHALL return to IDLE.
REQ-021 A request presented while a call is in DONE SHALL NOT be accepted until the cycle after the response handshake (no same-cycle turnaround).
REQ-022 rsp_out SHALL retain the last result after the handshake until the next call completes.
REQ-023 Arithmetic SHALL wrap modulo 16, with no saturation and no overflow flag.
REQ-024 req_valid in non-IDLE states SHALL be ignored; the caller must hold it until accepted.

Reset
REQ-025 On rst_n=0, the block SHALL immediately enter IDLE, with req_ready=1, rsp_valid=0, rsp_out=0 and a_loc, tmp and the counter all 0.
REQ-026 A reset mid-call SHALL abort the call without producing a response; the first acceptance is possible at the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro TASK_RESPONDER_TRACE_EN, when defined, SHALL add output ports dbg_valid (1 bit) and dbg_val (4 bits).
REQ-028 With the macro defined, dbg_valid SHALL pulse for one cycle at the REQ-017 edge with dbg_val=tmp, and again at the REQ-018 edge with dbg_val=rsp_out value; at all other times dbg_valid SHALL be 0.
REQ-029 Without the macro, neither dbg port SHALL exist and function SHALL be identical otherwise.

Verification (STEP_CYCLES=2, ADD_K=3, MUL_K=5)
REQ-030 req_a=2 accepted at E0, rsp_ready=1 -> rsp_valid rises at E0+4 with rsp_out=10; req_ready returns to 1 one cycle after the handshake.
REQ-031 req_a=5 -> rsp_out=9 (25 mod 16); req_a=0 -> rsp_out=0 (verifies wrap-around and zero handling).
REQ-032 req_a=2 accepted, then req_a driven to 7 at E0+1 -> rsp_out=10; rsp_out stays 0 (prior value) until E0+4.
REQ-033 rsp_ready held 0 for 3 cycles after rsp_valid rises, with a new req_valid pending -> rsp_out held stable, req_ready=0, and the new call accepted only after the handshake.
REQ-034 rst_n pulsed low at E0+3 -> rsp_valid=0, rsp_out=0 and req_ready=1 immediately, with no response emitted.
REQ-035 With TASK_RESPONDER_TRACE_EN defined and req_a=2 -> dbg pulse with value 5 at E0+2 and with value 10 at E0+4; with the macro undefined, the design builds without dbg ports.
